// File: rtl/spi_master_obi.sv
// SPI master with an OBI register port: one FRAME_BITS frame per START, MSB first,
// any CPOL/CPHA mode, divided SCLK, sticky DONE with level interrupt.
module spi_master_obi #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    FRAME_BITS = 8,
    parameter int                    NUM_CS     = 4,
    parameter int                    DIV_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    output logic                    obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic [NUM_CS-1:0]       spi_ss_o,
    output logic                    spi_sclk_o,
    output logic                    spi_mosi_o,
    input  logic                    spi_miso_i,
    output logic                    irq_o
);

    localparam int             ECW       = $clog2(2 * FRAME_BITS + 1);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    // Decoded register strobes for the beat accepted this cycle.
    typedef struct packed {
        logic ctrl;
        logic div;
        logic tx;
        logic status;
    } wsel_t;

    state_t                  state_q, state_d;
    logic [DIV_WIDTH-1:0]    cnt_q;
    logic [ECW-1:0]          edge_q;
    logic [FRAME_BITS-1:0]   tx_sh_q, rx_sh_q, rx_next;
    logic                    cpol_q, cpha_q, irq_en_q;
    logic [3:0]              cs_q;
    logic [DIV_WIDTH-1:0]    div_q;
    logic [FRAME_BITS-1:0]   txdata_q, rxdata_q;
    logic                    done_q, irq_q;
    logic [NUM_CS-1:0]       ss_q;
    logic                    sclk_q, mosi_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    accept, wr, rd, busy, mapped;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [2:0]              idx;
    wsel_t                   wsel;
    logic                    start, half_end, finish, done_clr;
    logic                    cpol_d, cpha_d, irq_en_d, done_d;
    logic [3:0]              cs_d;
    logic [DIV_WIDTH-1:0]    div_new, div_d;
    logic [FRAME_BITS-1:0]   tx_new, tx_d;
    logic [NUM_CS-1:0]       ss_sel;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic                    unused_bits;

    assign accept      = obi_req_i & rstn_i;
    assign obi_gnt_o   = accept;
    assign wr          = accept & obi_we_i;
    assign rd          = accept & ~obi_we_i;
    assign busy        = (state_q != IDLE);
    assign offset      = obi_addr_i - BASE_ADDR;
    assign idx         = offset[4:2];
    assign mapped      = (offset[ADDR_WIDTH-1:5] == '0);
    assign half_end    = (cnt_q == '0);
    assign finish      = (state_q == HOLD) & half_end;
    // Wide buses are only partially decoded; fold the leftover bits away.
    assign unused_bits = ^{obi_wdata_i, obi_be_i, offset[1:0]};

    always_comb begin
        wsel        = '0;
        wsel.ctrl   = wr & mapped & (idx == 3'd0) & ~busy;
        wsel.div    = wr & mapped & (idx == 3'd1) & ~busy;
        wsel.tx     = wr & mapped & (idx == 3'd2) & ~busy;
        wsel.status = wr & mapped & (idx == 3'd4);
    end

    // Byte-enable merge of the writable fields.
    always_comb begin
        div_new = div_q;
        tx_new  = txdata_q;
        for (int i = 0; i < DIV_WIDTH; i++)
            if (obi_be_i[i/8]) div_new[i] = obi_wdata_i[i];
        for (int i = 0; i < FRAME_BITS; i++)
            if (obi_be_i[i/8]) tx_new[i] = obi_wdata_i[i];
    end

    assign start    = wsel.ctrl & obi_be_i[0] & obi_wdata_i[0];
    assign cpol_d   = (wsel.ctrl & obi_be_i[0]) ? obi_wdata_i[1] : cpol_q;
    assign cpha_d   = (wsel.ctrl & obi_be_i[0]) ? obi_wdata_i[2] : cpha_q;
    assign irq_en_d = (wsel.ctrl & obi_be_i[0]) ? obi_wdata_i[3] : irq_en_q;
    assign cs_d     = (wsel.ctrl & obi_be_i[1]) ? obi_wdata_i[11:8] : cs_q;
    assign div_d    = wsel.div ? div_new : div_q;
    assign tx_d     = wsel.tx ? tx_new : txdata_q;
    assign done_clr = wsel.status & obi_be_i[0] & obi_wdata_i[1];
    assign done_d   = finish | (done_q & ~done_clr);

    // An out-of-range CS index leaves every select deasserted.
    always_comb begin
        ss_sel = '1;
        for (int i = 0; i < NUM_CS; i++)
            ss_sel[i] = (cs_d != 4'(i));
    end

    always_comb begin
        rx_next    = rx_sh_q << 1;
        rx_next[0] = spi_miso_i;
    end

    always_comb begin
        rd_val = '0;
        if (mapped) begin
            case (idx)
                3'd0: begin
                    rd_val[1]    = cpol_q;
                    rd_val[2]    = cpha_q;
                    rd_val[3]    = irq_en_q;
                    rd_val[11:8] = cs_q;
                end
                3'd1:    rd_val = DATA_WIDTH'(div_q);
                3'd2:    rd_val = DATA_WIDTH'(txdata_q);
                3'd3:    rd_val = DATA_WIDTH'(rxdata_q);
                3'd4:    rd_val[1:0] = {done_q, busy};
                default: rd_val = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (half_end) state_d = SHIFT;
            SHIFT:   if (half_end && edge_q == LAST_EDGE) state_d = HOLD;
            HOLD:    if (half_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            edge_q   <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            irq_en_q <= 1'b0;
            cs_q     <= '0;
            div_q    <= '0;
            txdata_q <= '0;
            rxdata_q <= '0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            ss_q     <= '1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= accept;
            rdata_q  <= rd ? rd_val : '0;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            irq_en_q <= irq_en_d;
            cs_q     <= cs_d;
            div_q    <= div_d;
            txdata_q <= tx_d;
            done_q   <= done_d;
            irq_q    <= done_d & irq_en_d;

            case (state_q)
                IDLE: begin
                    sclk_q <= cpol_d;
                    if (start) begin
                        cnt_q   <= div_q;
                        edge_q  <= '0;
                        ss_q    <= ss_sel;
                        rx_sh_q <= '0;
                        // CPHA=0 presents the MSB before the first edge.
                        if (cpha_d) begin
                            tx_sh_q <= txdata_q;
                        end else begin
                            mosi_q  <= txdata_q[FRAME_BITS-1];
                            tx_sh_q <= txdata_q << 1;
                        end
                    end
                end
                SETUP: cnt_q <= half_end ? div_q : cnt_q - 1'b1;
                SHIFT: begin
                    if (half_end) begin
                        cnt_q  <= div_q;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 1'b1;
                        if (!edge_q[0]) begin
                            if (cpha_q) begin
                                mosi_q  <= tx_sh_q[FRAME_BITS-1];
                                tx_sh_q <= tx_sh_q << 1;
                            end else begin
                                rx_sh_q <= rx_next;
                            end
                        end else begin
                            if (cpha_q) begin
                                rx_sh_q <= rx_next;
                            end else if (edge_q != LAST_EDGE) begin
                                mosi_q  <= tx_sh_q[FRAME_BITS-1];
                                tx_sh_q <= tx_sh_q << 1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        cnt_q    <= div_q;
                        ss_q     <= '1;
                        rxdata_q <= rx_sh_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign spi_ss_o     = ss_q;
    assign spi_sclk_o   = sclk_q;
    assign spi_mosi_o   = mosi_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_spi_master_obi.sv
// Directed bench for spi_master_obi: register table, then frame-level sequences
// covering modes, busy write drops, irq, unmapped CS and mid-frame reset.
module tb_spi_master_obi;

    logic        clk = 1'b0;
    logic        rstn;
    logic        obi_req, obi_gnt, obi_we, obi_rvalid;
    logic [31:0] obi_addr, obi_wdata, obi_rdata;
    logic [3:0]  obi_be;
    logic [3:0]  spi_ss;
    logic        spi_sclk, spi_mosi, spi_miso, irq;
    logic        loop_en, miso_const;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    assign spi_miso = loop_en ? spi_mosi : miso_const;

    spi_master_obi dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .obi_req_i    (obi_req),
        .obi_gnt_o    (obi_gnt),
        .obi_addr_i   (obi_addr),
        .obi_wdata_i  (obi_wdata),
        .obi_we_i     (obi_we),
        .obi_be_i     (obi_be),
        .obi_rvalid_o (obi_rvalid),
        .obi_rdata_o  (obi_rdata),
        .spi_ss_o     (spi_ss),
        .spi_sclk_o   (spi_sclk),
        .spi_mosi_o   (spi_mosi),
        .spi_miso_i   (spi_miso),
        .irq_o        (irq)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_sclk;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    function automatic vec_t mk(logic we, logic [31:0] a, logic [31:0] d,
                                logic [3:0] be, logic [31:0] e, logic s);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.be = be; v.exp_rd = e; v.exp_sclk = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One OBI beat; returns at the sample point one cycle after accept.
    task automatic obi_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] rdata);
        @(negedge clk);
        obi_req = 1'b1; obi_we = we; obi_addr = addr; obi_wdata = wdata; obi_be = be;
        #1 check("gnt", obi_gnt, 1);
        @(posedge clk); #1;
        obi_req = 1'b0; obi_we = 1'b0;
        check("rvalid", obi_rvalid, 1);
        rdata = obi_rdata;
        if (we) check("wr_rdata", rdata, 0);
    endtask

    // Watches one frame from the first busy cycle; rebuilds the word from MOSI
    // at the edges where a slave in this mode would sample.
    task automatic run_frame(input logic cpol, input logic cpha,
                             output int low, output int tog, output logic [7:0] word);
        logic prev;
        low = 0; tog = 0; word = '0; prev = spi_sclk;
        for (int i = 0; i < 400; i++) begin
            if (spi_ss == 4'hF) break;
            low++;
            if (spi_sclk != prev) begin
                tog++;
                if ((spi_sclk != cpol) == !cpha) word = {word[6:0], spi_mosi};
                prev = spi_sclk;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          low, tog, sslow;
        logic [7:0]  word;
        logic        prev;

        vecs[0]  = mk(0, 32'h00, 32'h0,        4'hF, 32'h0,    0);
        vecs[1]  = mk(0, 32'h04, 32'h0,        4'hF, 32'h0,    0);
        vecs[2]  = mk(0, 32'h10, 32'h0,        4'hF, 32'h0,    0);
        vecs[3]  = mk(1, 32'h04, 32'hFFFF,     4'h1, 32'h0,    0);
        vecs[4]  = mk(0, 32'h04, 32'h0,        4'hF, 32'hFF,   0);
        vecs[5]  = mk(1, 32'h04, 32'hABCD1234, 4'h3, 32'h0,    0);
        vecs[6]  = mk(0, 32'h04, 32'h0,        4'hF, 32'h1234, 0);
        vecs[7]  = mk(1, 32'h04, 32'hFFFF0001, 4'hC, 32'h0,    0);
        vecs[8]  = mk(0, 32'h04, 32'h0,        4'hF, 32'h1234, 0);
        vecs[9]  = mk(1, 32'h08, 32'h1A5,      4'hF, 32'h0,    0);
        vecs[10] = mk(0, 32'h08, 32'h0,        4'hF, 32'hA5,   0);
        vecs[11] = mk(1, 32'h0C, 32'h55,       4'hF, 32'h0,    0);
        vecs[12] = mk(0, 32'h0C, 32'h0,        4'hF, 32'h0,    0);
        vecs[13] = mk(1, 32'h00, 32'hF0E,      4'hF, 32'h0,    1);
        vecs[14] = mk(0, 32'h00, 32'h0,        4'hF, 32'hF0E,  1);
        vecs[15] = mk(1, 32'h00, 32'h301,      4'h2, 32'h0,    1);
        vecs[16] = mk(0, 32'h00, 32'h0,        4'hF, 32'h30E,  1);
        vecs[17] = mk(1, 32'h00, 32'h0,        4'hF, 32'h0,    0);
        vecs[18] = mk(0, 32'h1C, 32'h0,        4'hF, 32'h0,    0);
        vecs[19] = mk(1, 32'h1C, 32'hFFFFFFFF, 4'hF, 32'h0,    0);
        vecs[20] = mk(0, 32'h1C, 32'h0,        4'hF, 32'h0,    0);
        vecs[21] = mk(1, 32'h10, 32'h3,        4'hF, 32'h0,    0);
        vecs[22] = mk(0, 32'h10, 32'h0,        4'hF, 32'h0,    0);
        vecs[23] = mk(1, 32'h04, 32'h1,        4'hF, 32'h0,    0);
        vecs[24] = mk(0, 32'h04, 32'h0,        4'hF, 32'h1,    0);

        rstn = 1'b0; obi_req = 1'b0; obi_we = 1'b0; obi_addr = '0; obi_wdata = '0;
        obi_be = '0; loop_en = 1'b1; miso_const = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss", spi_ss, 4'hF);
        check("rst_sclk", spi_sclk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_rvalid", obi_rvalid, 0);
        check("rst_rdata", obi_rdata, 0);
        check("rst_irq", irq, 0);
        @(negedge clk) rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            obi_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_sclk", i), spi_sclk, vecs[i].exp_sclk);
        end

        // Mode 0, DIV=1, CS=2, TX=0xA5, MOSI looped to MISO.
        obi_xfer(1, 32'h08, 32'hA5, 4'hF, rd);
        obi_xfer(1, 32'h00, 32'h201, 4'hF, rd);
        check("m0_ss_start", spi_ss, 4'b1011);
        check("m0_mosi_msb", spi_mosi, 1);
        check("m0_sclk_start", spi_sclk, 0);
        run_frame(0, 0, low, tog, word);
        check("m0_busy_cycles", low, 36);
        check("m0_toggles", tog, 16);
        check("m0_mosi_word", word, 8'hA5);
        obi_xfer(0, 32'h0C, 0, 4'hF, rd);
        check("m0_rx", rd, 32'hA5);
        obi_xfer(0, 32'h10, 0, 4'hF, rd);
        check("m0_status", rd, 32'h2);
        check("m0_irq_off", irq, 0);

        // Modes 1..3, DIV=0, TX=0x3C, MISO tied high.
        loop_en = 1'b0; miso_const = 1'b1;
        obi_xfer(1, 32'h04, 32'h0, 4'hF, rd);
        obi_xfer(1, 32'h08, 32'h3C, 4'hF, rd);
        for (int m = 1; m < 4; m++) begin
            logic [31:0] mode_bits;
            mode_bits = (32'(m[0]) << 2) | (32'(m[1]) << 1);
            obi_xfer(1, 32'h00, mode_bits, 4'hF, rd);
            check($sformatf("mode%0d_idle_sclk", m), spi_sclk, 32'(m[1]));
            obi_xfer(1, 32'h00, mode_bits | 32'h1, 4'hF, rd);
            check($sformatf("mode%0d_ss", m), spi_ss, 4'b1110);
            if (!m[0]) check($sformatf("mode%0d_mosi_msb", m), spi_mosi, 0);
            run_frame(m[1], m[0], low, tog, word);
            check($sformatf("mode%0d_busy_cycles", m), low, 18);
            check($sformatf("mode%0d_toggles", m), tog, 16);
            check($sformatf("mode%0d_mosi_word", m), word, 8'h3C);
            check($sformatf("mode%0d_end_sclk", m), spi_sclk, 32'(m[1]));
            obi_xfer(0, 32'h0C, 0, 4'hF, rd);
            check($sformatf("mode%0d_rx", m), rd, 32'hFF);
        end

        // Writes while BUSY are acknowledged but dropped.
        obi_xfer(1, 32'h10, 32'h2, 4'hF, rd);
        obi_xfer(1, 32'h04, 32'h3, 4'hF, rd);
        obi_xfer(1, 32'h00, 32'h1, 4'hF, rd);
        obi_xfer(1, 32'h08, 32'h11, 4'hF, rd);
        @(posedge clk); #1;
        check("busy_rvalid_one_cycle", obi_rvalid, 0);
        obi_xfer(1, 32'h04, 32'h7, 4'hF, rd);
        obi_xfer(0, 32'h08, 0, 4'hF, rd);
        check("busy_tx_kept", rd, 32'h3C);
        obi_xfer(0, 32'h04, 0, 4'hF, rd);
        check("busy_div_kept", rd, 32'h3);
        obi_xfer(0, 32'h10, 0, 4'hF, rd);
        check("busy_status", rd, 32'h1);
        for (int i = 0; i < 200; i++) begin
            if (spi_ss == 4'hF) break;
            @(posedge clk); #1;
        end
        check("busy_frame_end", spi_ss, 4'hF);
        obi_xfer(0, 32'h10, 0, 4'hF, rd);
        check("busy_done", rd, 32'h2);

        // IRQ with an out-of-range CS: frame clocks, no select asserted.
        obi_xfer(1, 32'h10, 32'h2, 4'hF, rd);
        check("irq_cleared", irq, 0);
        obi_xfer(1, 32'h04, 32'h0, 4'hF, rd);
        obi_xfer(1, 32'h00, 32'h508, 4'hF, rd);
        check("irq_en_no_done", irq, 0);
        obi_xfer(1, 32'h00, 32'h509, 4'hF, rd);
        sslow = 0; tog = 0; prev = spi_sclk;
        for (int i = 0; i < 30; i++) begin
            if (spi_ss != 4'hF) sslow++;
            if (spi_sclk != prev) begin tog++; prev = spi_sclk; end
            @(posedge clk); #1;
        end
        check("cs5_ss_never_low", sslow, 0);
        check("cs5_toggles", tog, 16);
        check("irq_set", irq, 1);
        obi_xfer(1, 32'h10, 32'h2, 4'hF, rd);
        check("irq_w1c", irq, 0);

        // Reset in the middle of SHIFT.
        loop_en = 1'b1;
        obi_xfer(1, 32'h04, 32'h1, 4'hF, rd);
        obi_xfer(1, 32'h00, 32'h1, 4'hF, rd);
        repeat (10) @(posedge clk);
        #1 check("rst_mid_active", spi_ss, 4'hE);
        @(negedge clk);
        rstn = 1'b0; obi_req = 1'b1; obi_we = 1'b0; obi_addr = 32'h10;
        #1 check("rst_gnt_low", obi_gnt, 0);
        @(posedge clk); #1;
        check("rst_mid_ss", spi_ss, 4'hF);
        check("rst_mid_sclk", spi_sclk, 0);
        check("rst_mid_mosi", spi_mosi, 0);
        check("rst_mid_rvalid", obi_rvalid, 0);
        @(negedge clk);
        rstn = 1'b1; obi_req = 1'b0;
        obi_xfer(0, 32'h10, 0, 4'hF, rd);
        check("rst_mid_status", rd, 32'h0);
        obi_xfer(0, 32'h0C, 0, 4'hF, rd);
        check("rst_mid_rx", rd, 32'h0);
        obi_xfer(0, 32'h04, 0, 4'hF, rd);
        check("rst_mid_div", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
